demux_deserializer: RTL and testbench
=====================================

Name: demux_deserializer

Overview:
- Inverse of the N:1 bit multiplexer `mux_module`: routes a 1-bit serial input back into an N-bit registered word.
- Addressed mode: each valid bit is written to the output bit picked by `select`.
- Frame mode: an internal counter sweeps bit positions 0..N-1 and the assembled word is published atomically with a valid pulse.
- Sits at the receiving end of any path that serialises a word through `mux_module` with an incrementing select.

Parameters:
- N, 16, output word width (number of demux destinations); N >= 2.
- m, $clog2(N), width of select and of the internal bit index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- inp  input  1  serial data bit.
- in_valid  input  1  inp is valid this cycle.
- select  input  m  destination bit index (addressed mode only).
- auto_mode  input  1  0 = addressed mode, 1 = frame mode; sampled only in IDLE.
- start  input  1  begin (or restart) a frame when auto_mode=1.
- out  output  N  registered output word.
- out_valid  output  1  one-cycle pulse: out was updated on the previous edge.
- busy  output  1  frame collection in progress.
- drop_err  output  1  sticky: a valid bit was discarded.

Behaviour:
- Reset (rst=1 at a clk edge; overrides all other inputs):
  - out=0, out_valid=0, busy=0, drop_err=0.
  - Index=0, shadow register=0, state=IDLE.
  - Reset asserted mid-frame abandons the frame with no out_valid.
- All outputs are registered.
- States: IDLE, COLLECT.
- IDLE, auto_mode=0 (addressed mode):
  - in_valid=1: out[select] <= inp; all other out bits hold; out_valid=1 next cycle.
  - select >= N (only possible when N is not a power of 2): write discarded, drop_err set, no out_valid.
  - start is ignored.
- IDLE, auto_mode=1:
  - start=1: go to COLLECT, index=0, shadow=0, drop_err cleared, busy=1 from the next cycle.
  - in_valid=1 with start=0: bit discarded, drop_err set.
  - in_valid=1 together with start=1: that bit is NOT captured. The frame begins on the following cycle.
- COLLECT:
  - select and auto_mode are ignored.
  - in_valid=1: shadow[index] <= inp. Bits are LSB-first, index 0 first.
  - Accepted bit with index < N-1: index increments.
  - Accepted bit with index = N-1 (last bit):
    - out <= shadow with bit N-1 = inp, all N bits updated in one edge.
    - out_valid=1 on the next cycle.
    - busy=0 on the next cycle; return to IDLE; index=0.
  - in_valid=0: hold state, index and shadow. Gaps of any length are allowed.
  - start=1 in COLLECT: restart. Index=0, shadow=0, any in_valid bit that cycle is discarded (drop_err NOT set), out unchanged, stay in COLLECT.
  - out holds the previous frame's value for the whole of COLLECT.
- Latency:
  - Addressed write: 1 cycle from the in_valid edge to out and out_valid.
  - Frame mode: out and out_valid are updated 1 cycle after the last accepted bit.
  - Minimum frame duration: N cycles after the start cycle.
- drop_err is cleared only by rst or by an accepted start.
- Index wrap: the index never exceeds N-1. Index is m bits wide; no modulo arithmetic is needed beyond the N-1 compare.
- out_valid is never asserted for two consecutive cycles, except for back-to-back addressed writes (one pulse per write).

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> out=16'h0000, out_valid=0, busy=0, drop_err=0.
2. Addressed mode, auto_mode=0:
   - Write inp=1 at select=0, then select=8, then select=15 -> out = 16'h0001, 16'h0101, 16'h8101 after successive writes, one out_valid pulse each.
   - Then inp=0 at select=0 -> out=16'h8100.
3. Frame mode:
   - start, then 16 consecutive valid bits of word 16'hA5C3, LSB first -> out=16'hA5C3 with out_valid exactly one cycle after the 16th bit, busy high for exactly 16 cycles, out unchanged during collection.
   - Repeat with random in_valid gaps -> identical result.
4. Restart and drop:
   - start, 7 bits of ones, start again, 16 bits of 16'h0F0F -> out=16'h0F0F, single out_valid pulse, drop_err=0.
   - Then, in IDLE with auto_mode=1, in_valid=1 without start -> drop_err=1, out unchanged.
5. Reset mid-frame: start, 10 bits, rst for 1 cycle -> out=0, busy=0, no out_valid.
   - Then start + 16 bits of 16'hFFFF -> out=16'hFFFF.
6. Loopback with `mux_module` (N=16): drive mux_module.select from a 0..15 counter, feed its output into inp in frame mode, for input words 16'h0000, 16'h0001, 16'h8001, 16'h0101 -> out equals each input word in turn.

Source files
------------

// File: rtl/demux_deserializer.sv
// demux_deserializer: turns a 1-bit serial stream back into an N-bit registered word.
//   Addressed mode (auto_mode=0): each valid bit is written to out[select].
//   Frame mode (auto_mode=1): start opens a frame, then N valid bits are gathered
//   LSB-first into a shadow word and published to out in a single edge.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   inp, in_valid  serial data bit and its qualifier
//   select         destination bit index (addressed mode)
//   auto_mode      mode select, sampled only in IDLE
//   start          begin or restart a frame
//   out            registered output word
//   out_valid      one-cycle pulse: out changed on the previous edge
//   busy           frame collection in progress
//   drop_err       sticky flag: a valid bit was discarded
module demux_deserializer #(
   parameter int unsigned N = 16,
   parameter int unsigned M = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inp,
   input  logic         in_valid,
   input  logic [M-1:0] select,
   input  logic         auto_mode,
   input  logic         start,
   output logic [N-1:0] out,
   output logic         out_valid,
   output logic         busy,
   output logic         drop_err
);

   localparam logic [0:0]   S_IDLE    = 1'b0;
   localparam logic [0:0]   S_COLLECT = 1'b1;
   localparam logic [M-1:0] LAST_IDX  = M'(N - 1);

   logic [0:0]   state_q,     state_d;
   logic [M-1:0] idx_q,       idx_d;
   logic [N-1:0] shadow_q,    shadow_d;
   logic [N-1:0] out_q,       out_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q,      busy_d;
   logic         drop_err_q,  drop_err_d;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         shadow_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         drop_err_q  <= drop_err_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      drop_err_d  = drop_err_q;

      case (state_q)
         S_IDLE: begin
            if (!auto_mode) begin
               if (in_valid) begin
                  // Out-of-range select only exists when N is not a power of two
                  if (32'(select) < N) begin
                     out_d[select] = inp;
                     out_valid_d   = 1'b1;
                  end else begin
                     drop_err_d = 1'b1;
                  end
               end
            end else if (start) begin
               // Any bit arriving with start is not part of the frame
               state_d    = S_COLLECT;
               idx_d      = '0;
               shadow_d   = '0;
               drop_err_d = 1'b0;
               busy_d     = 1'b1;
            end else if (in_valid) begin
               drop_err_d = 1'b1;
            end
         end

         default: begin
            if (start) begin
               // Restart: the coincident bit is silently discarded
               idx_d    = '0;
               shadow_d = '0;
            end else if (in_valid) begin
               if (idx_q == LAST_IDX) begin
                  out_d         = shadow_q;
                  out_d[N-1]    = inp;
                  out_valid_d   = 1'b1;
                  busy_d        = 1'b0;
                  state_d       = S_IDLE;
                  idx_d         = '0;
               end else begin
                  shadow_d[idx_q] = inp;
                  idx_d           = idx_q + M'(1);
               end
            end
         end
      endcase
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_demux_deserializer.sv
// Directed bench for demux_deserializer (N=16): a queue-based behavioural model
// checked every cycle, plus literal expectations at key points.
module tb_demux_deserializer;

   localparam int unsigned N = 16;
   localparam int unsigned M = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         inp = 1'b0;
   logic         in_valid = 1'b0;
   logic [M-1:0] select = '0;
   logic         auto_mode = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] out;
   logic         out_valid;
   logic         busy;
   logic         drop_err;

   int vectors = 0;
   int errors  = 0;

   demux_deserializer #(.N(N), .M(M)) dut (
      .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .select(select),
      .auto_mode(auto_mode), .start(start), .out(out), .out_valid(out_valid),
      .busy(busy), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   // Behavioural model: frame bits gathered in a queue, word formed once N arrive
   logic [N-1:0] m_out  = '0;
   bit           m_ov   = 1'b0;
   bit           m_busy = 1'b0;
   bit           m_drop = 1'b0;
   bit           m_in_frame = 1'b0;
   bit           frame_bits[$];
   bit           model_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_out = '0; m_ov = 0; m_busy = 0; m_drop = 0; m_in_frame = 0;
         frame_bits.delete();
         model_live = 1'b1;
      end else begin
         m_ov = 0;
         if (!m_in_frame) begin
            if (!auto_mode) begin
               if (in_valid) begin
                  if (int'(select) < N) begin m_out[select] = inp; m_ov = 1; end
                  else m_drop = 1;
               end
            end else if (start) begin
               m_in_frame = 1; m_busy = 1; m_drop = 0;
               frame_bits.delete();
            end else if (in_valid) begin
               m_drop = 1;
            end
         end else if (start) begin
            frame_bits.delete();
         end else if (in_valid) begin
            frame_bits.push_back(inp);
            if (frame_bits.size() == N) begin
               for (int i = 0; i < N; i++) m_out[i] = frame_bits[i];
               m_ov = 1; m_busy = 0; m_in_frame = 0;
               frame_bits.delete();
            end
         end
      end
      #1;
      if (model_live) begin
         cmp("out", out, m_out);
         cmp("out_valid", N'(out_valid), N'(m_ov));
         cmp("busy", N'(busy), N'(m_busy));
         cmp("drop_err", N'(drop_err), N'(m_drop));
      end
   end

   task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then wait until the post-edge outputs are stable
   task automatic cyc(input bit r, input bit i, input bit v, input logic [M-1:0] s,
                      input bit am, input bit st);
      rst = r; inp = i; in_valid = v; select = s; auto_mode = am; start = st;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cyc(0, 0, 0, '0, 1, 0);
   endtask

   int busy_cnt;

   // Start a frame then send word LSB-first, optionally with random gaps
   task automatic send_frame(input logic [N-1:0] w, input bit gaps, input bit bit_with_start);
      cyc(0, 1, bit_with_start, 4'($urandom_range(0, 15)), 1, 1);
      busy_cnt = busy ? 1 : 0;
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            int g = int'($urandom_range(0, 3));
            for (int k = 0; k < g; k++) begin
               cyc(0, 1'($urandom), 0, 4'($urandom), 1'($urandom), 0);
               if (busy) busy_cnt++;
            end
         end
         cyc(0, w[i], 1, 4'($urandom), 1'($urandom), 0);
         if (busy) busy_cnt++;
      end
   endtask

   logic [N-1:0] lb_words [4];
   logic [N-1:0] lb_w;
   logic [M-1:0] mux_sel;

   initial begin
      // Reset with random inputs
      for (int k = 0; k < 2; k++) cyc(1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      cmp("reset_out", out, 16'h0000);
      cmp("reset_flags", N'({out_valid, busy, drop_err}), N'(0));

      // Addressed mode
      cyc(0, 1, 1, 4'd0, 0, 1);  cmp("addr_sel0", out, 16'h0001); cmp("addr_ov0", N'(out_valid), N'(1));
      cyc(0, 1, 1, 4'd8, 0, 0);  cmp("addr_sel8", out, 16'h0101);
      cyc(0, 1, 1, 4'd15, 0, 0); cmp("addr_sel15", out, 16'h8101);
      cyc(0, 0, 1, 4'd0, 0, 0);  cmp("addr_clr0", out, 16'h8100);
      cyc(0, 0, 0, 4'd3, 0, 0);  cmp("addr_ov_drop", N'(out_valid), N'(0));

      // Frame mode, back-to-back bits
      send_frame(16'hA5C3, 0, 0);
      cmp("frame_out", out, 16'hA5C3);
      cmp("frame_ov", N'(out_valid), N'(1));
      cmp("frame_busy_cycles", N'(busy_cnt), N'(16));
      idle();
      cmp("frame_ov_single", N'(out_valid), N'(0));

      // Frame mode with gaps; bit coincident with start must be ignored
      send_frame(16'hA5C3, 1, 1);
      cmp("gap_out", out, 16'hA5C3);
      idle();

      // Restart mid-frame
      cyc(0, 0, 0, '0, 1, 1);
      for (int k = 0; k < 7; k++) cyc(0, 1, 1, '0, 1, 0);
      send_frame(16'h0F0F, 0, 1);
      cmp("restart_out", out, 16'h0F0F);
      cmp("restart_drop", N'(drop_err), N'(0));
      idle();
      cyc(0, 1, 1, '0, 1, 0);
      cmp("idle_drop", N'(drop_err), N'(1));
      cmp("idle_drop_out", out, 16'h0F0F);

      // Reset mid-frame
      cyc(0, 0, 0, '0, 1, 1);
      for (int k = 0; k < 10; k++) cyc(0, 1, 1, '0, 1, 0);
      cyc(1, 1, 1, '0, 1, 0);
      cmp("midrst_out", out, 16'h0000);
      cmp("midrst_flags", N'({out_valid, busy}), N'(0));
      send_frame(16'hFFFF, 0, 0);
      cmp("after_rst_out", out, 16'hFFFF);
      idle();

      // Loopback through an N:1 mux driven by an incrementing select
      lb_words[0] = 16'h0000; lb_words[1] = 16'h0001;
      lb_words[2] = 16'h8001; lb_words[3] = 16'h0101;
      for (int w = 0; w < 4; w++) begin
         lb_w = lb_words[w];
         cyc(0, 0, 0, '0, 1, 1);
         for (int c = 0; c < N; c++) begin
            mux_sel = M'(c);
            cyc(0, lb_w[mux_sel], 1, '0, 1, 0);
         end
         cmp("loopback_out", out, lb_w);
         idle();
      end

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
